// File: rtl/counter_pkg.sv
// counter_pkg: shared constants, count type and load clamp for the up/down counter family.
package counter_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef logic [DEFAULT_WIDTH-1:0] count_t;
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulus);
    return (val > modulus - 1) ? modulus - 1 : val;
  endfunction
endpackage

// File: rtl/count_reg.sv
// count_reg: WIDTH-bit D register with asynchronous active-high reset to zero.
module count_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/up_counter_mod.sv
// up_counter_mod: modulo-N up counter with enable, clear, clamped load, carry and wrap pulse.
// Define UP_COUNTER_MOD_ONESHOT_EN to stop at MODULUS-1 instead of wrapping.
module up_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("up_counter_mod: MODULUS out of range 2..2**WIDTH");
  end
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);
  logic [WIDTH-1:0] w_q, w_d, w_clamp, w_roll;
  logic [WIDTH:0]   w_inc;
  logic             w_term, w_wrap_d, r_wrap;
  count_reg #(.WIDTH(WIDTH)) u_count (.clk(clk), .rst(reset), .i_d(w_d), .o_q(w_q));
  // Terminal detected on the widened increment so MODULUS == 2**WIDTH needs no special case
  assign w_inc   = {1'b0, w_q} + (WIDTH+1)'(1);
  assign w_term  = w_inc == MOD;
  assign w_clamp = WIDTH'(clamp_load(32'(load_val), MODULUS));
  assign tc      = w_term && en;
`ifdef UP_COUNTER_MOD_ONESHOT_EN
  assign w_roll   = w_q;
  assign w_wrap_d = 1'b0;
`else
  assign w_roll   = '0;
  assign w_wrap_d = !clear && !load && tc;
`endif
  always_comb begin
    w_d = clear ? '0 : load ? w_clamp : en ? (w_term ? w_roll : w_inc[WIDTH-1:0]) : w_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_wrap <= 1'b0;
    else r_wrap <= w_wrap_d;
  assign q    = w_q;
  assign wrap = r_wrap;
endmodule

// File: tb/tb_up_counter_mod.sv
// tb_up_counter_mod: directed table and sequence checks for up_counter_mod.
module tb_up_counter_mod;
`ifdef UP_COUNTER_MOD_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       r10 = 1'b1, c10 = 1'b0, l10 = 1'b0, e10 = 1'b0;
  logic [3:0] v10 = '0;
  logic [3:0] q10;
  logic       t10, w10;
  logic       r16 = 1'b1, c16 = 1'b0, l16 = 1'b0, e16 = 1'b0;
  logic [3:0] v16 = '0;
  logic [3:0] q16;
  logic       t16, w16;
  logic       rc = 1'b1;
  logic [3:0] qlo, qhi;
  logic       tlo, thi, wlo, whi;
  int n_tests = 0, n_fail = 0;
  up_counter_mod #(.WIDTH(4), .MODULUS(10)) u10 (.clk(clk), .reset(r10), .en(e10), .clear(c10),
    .load(l10), .load_val(v10), .q(q10), .tc(t10), .wrap(w10));
  up_counter_mod #(.WIDTH(4), .MODULUS(16)) u16 (.clk(clk), .reset(r16), .en(e16), .clear(c16),
    .load(l16), .load_val(v16), .q(q16), .tc(t16), .wrap(w16));
  up_counter_mod #(.WIDTH(4), .MODULUS(10)) ulo (.clk(clk), .reset(rc), .en(1'b1), .clear(1'b0),
    .load(1'b0), .load_val(4'd0), .q(qlo), .tc(tlo), .wrap(wlo));
  up_counter_mod #(.WIDTH(4), .MODULUS(10)) uhi (.clk(clk), .reset(rc), .en(tlo), .clear(1'b0),
    .load(1'b0), .load_val(4'd0), .q(qhi), .tc(thi), .wrap(whi));
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  typedef struct packed {
    logic c, l, e;
    logic [3:0] v, q;
    logic t, w;
  } vec_t;
  vec_t tbl[12];
  initial begin
    int eq, pq, elo, ehi;
    bit ptc;
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'd5,  4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'd5,  4'd5, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 4'd13, 4'd9, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'd9,  4'd9, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'd2,  4'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'd8,  4'd8, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd9, 1'b1, 1'b0};
`ifdef UP_COUNTER_MOD_ONESHOT_EN
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd9, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 1'b0};
`else
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0};
`endif
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0};
    e10 = 1'b1;
    e16 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_q10", q10, 0);
    check("reset_tc10", t10, 0);
    check("reset_wrap10", w10, 0);
    check("reset_q16", q16, 0);
    check("reset_qlo", qlo, 0);
    check("reset_qhi", qhi, 0);
    r10 = 1'b0;
    r16 = 1'b0;
    rc  = 1'b0;
    e16 = 1'b0;
    elo = 0;
    ehi = 0;
    for (int i = 0; i < 12; i++) begin
      {c10, l10, e10, v10} = {tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].v};
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), q10, tbl[i].q);
      check($sformatf("vec%0d_tc", i), t10, tbl[i].t);
      check($sformatf("vec%0d_wrap", i), w10, tbl[i].w);
      ptc = (elo == 9);
      elo = (elo == 9) ? (OS ? 9 : 0) : elo + 1;
      if (ptc) ehi = (ehi == 9) ? (OS ? 9 : 0) : ehi + 1;
    end
    {c10, l10, e10, v10} = {1'b0, 1'b1, 1'b0, 4'd7};
    @(posedge clk);
    #1;
    check("preload7", q10, 7);
    l10 = 1'b0;
    e10 = 1'b1;
    #2;
    r10 = 1'b1;
    #1;
    check("async_reset_q", q10, 0);
    check("async_reset_wrap", w10, 0);
    check("async_reset_tc", t10, 0);
    @(negedge clk);
    r10 = 1'b0;
    eq = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      pq = eq;
      eq = (eq == 9) ? (OS ? 9 : 0) : eq + 1;
      check($sformatf("run%0d_q", i), q10, eq);
      check($sformatf("run%0d_wrap", i), w10, (!OS && pq == 9) ? 1 : 0);
      check($sformatf("run%0d_tc", i), t10, (eq == 9) ? 1 : 0);
      ptc = (elo == 9);
      elo = (elo == 9) ? (OS ? 9 : 0) : elo + 1;
      if (ptc) ehi = (ehi == 9) ? (OS ? 9 : 0) : ehi + 1;
    end
    {e10, c10} = 2'b01;
    @(posedge clk);
    #1;
    check("clear_restart_q", q10, 0);
    c10 = 1'b0;
    e10 = 1'b1;
    @(posedge clk);
    #1;
    check("after_clear_q", q10, 1);
    ptc = (elo == 9);
    elo = (elo == 9) ? (OS ? 9 : 0) : elo + 1;
    if (ptc) ehi = (ehi == 9) ? (OS ? 9 : 0) : ehi + 1;
    ptc = (elo == 9);
    elo = (elo == 9) ? (OS ? 9 : 0) : elo + 1;
    if (ptc) ehi = (ehi == 9) ? (OS ? 9 : 0) : ehi + 1;
    {l16, v16, e16} = {1'b1, 4'd3, 1'b0};
    @(posedge clk);
    #1;
    l16 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold16_q", q16, 3);
      check("hold16_tc", t16, 0);
      check("hold16_wrap", w16, 0);
    end
    {l16, v16} = {1'b1, 4'd15};
    @(posedge clk);
    #1;
    check("load15_q", q16, 15);
    check("load15_tc_en0", t16, 0);
    l16 = 1'b0;
    e16 = 1'b1;
    #1;
    check("load15_tc_en1", t16, 1);
    @(posedge clk);
    #1;
    check("bin_wrap_q", q16, OS ? 15 : 0);
    check("bin_wrap_pulse", w16, OS ? 0 : 1);
    @(posedge clk);
    #1;
    check("bin_wrap_next_q", q16, OS ? 15 : 1);
    check("bin_wrap_once", w16, 0);
    rc = 1'b1;
    #1;
    check("casc_reset", {qhi, qlo}, 0);
    @(negedge clk);
    rc = 1'b0;
    elo = 0;
    ehi = 0;
    for (int i = 0; i < 101; i++) begin
      @(posedge clk);
      #1;
      ptc = (elo == 9);
      elo = (elo == 9) ? (OS ? 9 : 0) : elo + 1;
      if (ptc) ehi = (ehi == 9) ? (OS ? 9 : 0) : ehi + 1;
      check($sformatf("casc%0d", i), {qhi, qlo}, {ehi[3:0], elo[3:0]});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/up_counter_mod.md
Name: up_counter_mod

Overview:
- Modulo-N up counter with enable, synchronous clear, parallel load and a cascade carry output.
- Counterpart to the team's 4-bit down counter: counts in the opposite direction, with a carry output in place of the down counter's borrow.
- Used as a BCD/decade digit, a timer prescaler, or a cascaded stage in multi-digit up counters.
- Default configuration is 4 bits, modulus 16.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range is 0 to MODULUS-1. Legal range is 2 to 2**WIDTH; elaboration fails outside it.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  count enable; count advances by 1 per cycle when high
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value captured on load
- q  output  WIDTH  current count, registered
- tc  output  1  terminal count/carry-out, combinational: (q == MODULUS-1) && en
- wrap  output  1  registered one-cycle pulse, high in the cycle after q went from MODULUS-1 to 0 by counting

Behaviour:
- Reset:
  - The reset level forces q=0 and wrap=0 immediately, independent of clk.
  - Counting resumes at the first rising clk edge after reset deasserts.
  - tc is 0 during reset, since q=0 and MODULUS>=2.
- Priority at each rising edge: reset > clear > load > en > hold.
- clear=1: q<=0 and wrap<=0. load and en are ignored.
- load=1 (clear=0):
  - q<=load_val if load_val <= MODULUS-1; otherwise q<=MODULUS-1 (saturating clamp).
  - wrap<=0. en is ignored that cycle.
- en=1 (no clear, no load):
  - q<MODULUS-1: q<=q+1.
  - q==MODULUS-1: q<=0 and wrap<=1.
- Otherwise q holds and wrap<=0. wrap is never high for two consecutive cycles unless MODULUS counts occur back to back, which cannot happen because MODULUS>=2.
- Arithmetic:
  - The increment is computed at WIDTH+1 bits internally.
  - The wrap is an explicit compare against MODULUS-1, not natural overflow, so non-power-of-two moduli are exact.
  - When MODULUS == 2**WIDTH, behaviour equals a plain binary wrap.
- Latency: q changes 1 cycle after the qualifying edge; tc follows q and en combinationally in the same cycle.
- Cascading: a higher stage connects en_hi = tc_lo. Both stages advance on the same edge, giving a ripple-free synchronous cascade.
- Reset mid-count: immediate asynchronous return to 0. No partial or glitch state is visible on q after reset asserts.
- State is held only in q_reg and wrap_reg. Next-state logic is a pure combinational block; the output is driven directly from the registers.

Optional Feature:
- Macro: UP_COUNTER_MOD_ONESHOT_EN.
- Defined (one-shot mode):
  - With en=1, the counter stops at MODULUS-1 instead of wrapping.
  - q holds at MODULUS-1 and wrap never asserts.
  - tc stays high while en=1 at terminal.
  - Only clear, load or reset restarts counting.
- Undefined: normal modulo wrap as described above.
- The port list is identical in both builds.

Decomposition:
- Shared package counter_pkg:
  - Constant DEFAULT_WIDTH=4.
  - Typedef count_t for a WIDTH-bit count.
  - Function clamp_load(val, modulus), shared with the down counter.
- One natural sub-module, count_reg: WIDTH-parameterised D register with asynchronous active-high reset to 0. It holds q_reg, and the counter instantiates it once for the count.
- wrap_reg stays in the top-level module.

Test Plan:
1. Reset and count, MODULUS=10, WIDTH=4: assert reset mid-count at q=7 -> q=0 immediately, with no clk edge needed. Release and hold en=1 for 12 cycles -> q=0,1,...,9,0,1; wrap high exactly one cycle, after the 9->0 transition; tc high only while q=9.
2. Priority, MODULUS=10: clear=1, load=1, load_val=5, en=1 in the same cycle -> q=0. Next cycle load=1, en=1, load_val=5 -> q=5, not 6.
3. Load clamp, MODULUS=10: load_val=4'd13 -> q=9; tc=1 when en=1.
4. Hold, MODULUS=16: en=0 for 5 cycles at q=3 -> q stays 3, tc=0, wrap=0. Then en=1 from q=15 -> q=0 and wrap pulses (binary wrap).
5. Cascade, two MODULUS=10 instances with en_hi=tc_lo and en_lo=1: run 100 cycles -> {q_hi,q_lo} goes 00..99 then 00; q_hi increments on the same edge as q_lo 9->0.
6. UP_COUNTER_MOD_ONESHOT_EN defined, MODULUS=10, en=1 for 15 cycles -> q saturates at 9, wrap stays 0, tc=1. A clear then restarts the count from 0.
